down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter DC_WIDTH, default 3, counter width in bits (legal range 1..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port clr_i  input  1  reset clr_i, asynchronous, active-low.
REQ-004 SHALL have port load  input  1  load load_val and start counting.
REQ-005 SHALL have port load_val  input  DC_WIDTH  terminal-count start/reload value.
REQ-006 SHALL have port en  input  1  count enable (tick qualifier).
REQ-007 SHALL have port auto  input  1  1 = auto-reload (divide-by-N), 0 = one-shot.
REQ-008 SHALL have port count  output  DC_WIDTH  current count.
REQ-009 SHALL have port count_n  output  DC_WIDTH  bitwise inverse of count.
REQ-010 SHALL have port tc  output  1  one-cycle terminal-count pulse.
REQ-011 SHALL have port done  output  1  sticky one-shot completion flag.
REQ-012 SHALL have port busy  output  1  high while state is RUN.

Function
REQ-013 SHALL be fully synchronous to rising clk except reset; all outputs except count_n are registered.
REQ-014 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-015 SHALL hold a reload register captured from load_val on every accepted load.
REQ-016 SHALL give load priority over en in every state; load with load_val!=0 sets count=load_val, state=RUN, tc=0 next cycle.
REQ-017 SHALL, on load with load_val==0, set count=0, state=IDLE, with no tc pulse.
REQ-018 SHALL define a tick as en==1 while state==RUN and load==0 (plus the prescaler condition when enabled).
REQ-019 SHALL, on a tick with count>1, decrement count by 1.
REQ-020 SHALL, on a tick with count==1 and auto==1, set count=reload, stay in RUN, and assert tc for the following cycle only (period = reload ticks).
REQ-021 SHALL, on a tick with count==1 and auto==0, set count=0, enter DONE, and assert tc for the following cycle only.
REQ-022 SHALL hold count when en==0 (pause); resuming continues from the held value.
REQ-023 SHALL ignore en in IDLE and DONE; DONE is left only by load or reset.
REQ-024 SHALL sample auto only at the count==1 tick; changing auto mid-run affects only that decision.
REQ-025 SHALL drive count_n = ~count combinationally at all times.

Reset
REQ-026 SHALL, while clr_i==0, immediately force count=0, reload=0, state=IDLE, tc=0, done=0, busy=0, prescaler count=0, including mid-RUN.
REQ-027 SHALL ignore load and en on the first rising edge while clr_i is still low; normal operation resumes on the first edge after deassertion.

Configuration
REQ-028 SHALL, when DOWN_COUNTER_PRESCALE_EN is defined, add parameter PS_WIDTH (default 4) and input prescale[PS_WIDTH-1:0], qualifying ticks so count decrements once per prescale+1 enabled RUN cycles; the prescaler clears on load, on tc, and on reset.
REQ-029 SHALL, when DOWN_COUNTER_PRESCALE_EN is undefined, have neither the prescale port nor the parameter, and decrement on every enabled RUN cycle.

Structure
REQ-030 SHALL place typedef dc_state_e (IDLE, RUN, DONE) and width-limit constants in package down_counter_pkg.
REQ-031 SHALL implement the prescaler as sub-module down_counter_prescaler, instantiated only under DOWN_COUNTER_PRESCALE_EN.

Verification
REQ-032 SHALL cover one-shot: DC_WIDTH=3, auto=0, en=1, load 5 at cycle 0 -> count 5,4,3,2,1,0 on cycles 1-6; tc=1 on cycle 6 only; done=1 from cycle 6; busy=0 from cycle 6.
REQ-033 SHALL cover auto-reload: auto=1, en=1, load 3 -> count 3,2,1,3,2,1...; tc high for one cycle in every 3; done stays 0.
REQ-034 SHALL cover zero load and pause: load 0 -> count=0, IDLE, no tc; load 4 then en=0 for 5 cycles at count=2 -> count holds 2 and resumes to 1 when en=1.
REQ-035 SHALL cover reset and reload mid-run: clr_i low at count=4 -> count=0, busy=0 before the next edge; load 6 with en=1 at count=3 -> count=6 next cycle, no tc.
REQ-036 SHALL cover the prescaler (macro defined): prescale=1, load 2, en=1 -> count 2,2,1,1,0; tc once; undefined build -> count 2,1,0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared types and width limits for the down_counter block.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dc_state_e;

  localparam int DC_WIDTH_MIN     = 1;
  localparam int DC_WIDTH_MAX     = 16;
  localparam int PS_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/down_counter_prescaler.sv
// Tick prescaler for down_counter: passes one advance in every prescale+1,
// restarting its phase on clear or whenever it emits a tick.
module down_counter_prescaler
  import down_counter_pkg::*;
#(
  parameter int PS_WIDTH = PS_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                clear,
  input  logic                advance,
  input  logic [PS_WIDTH-1:0] prescale,
  output logic                tick
);

  logic [PS_WIDTH-1:0] ps_cnt_reg;
  logic [PS_WIDTH-1:0] ps_cnt_next;

  assign tick = advance && (ps_cnt_reg == prescale);

  always_comb begin
    ps_cnt_next = ps_cnt_reg;
    if (clear || tick) begin
      ps_cnt_next = '0;
    end else if (advance) begin
      ps_cnt_next = ps_cnt_reg + PS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_i) begin
    if (!clr_i) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_next;
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with one-shot / auto-reload modes and a terminal-count
// pulse. Define DOWN_COUNTER_PRESCALE_EN to add the tick prescaler.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int DC_WIDTH = 3
`ifdef DOWN_COUNTER_PRESCALE_EN
  ,
  parameter int PS_WIDTH = PS_WIDTH_DEFAULT
`endif
) (
  input  logic                clk,
  input  logic                clr_i,
  input  logic                load,
  input  logic [DC_WIDTH-1:0] load_val,
  input  logic                en,
  input  logic                auto,
`ifdef DOWN_COUNTER_PRESCALE_EN
  input  logic [PS_WIDTH-1:0] prescale,
`endif
  output logic [DC_WIDTH-1:0] count,
  output logic [DC_WIDTH-1:0] count_n,
  output logic                tc,
  output logic                done,
  output logic                busy
);

  if (DC_WIDTH < DC_WIDTH_MIN || DC_WIDTH > DC_WIDTH_MAX) begin : g_bad_width
    $error("down_counter: DC_WIDTH out of range");
  end

  dc_state_e           state_reg, state_next;
  logic [DC_WIDTH-1:0] count_reg, count_next;
  logic [DC_WIDTH-1:0] reload_reg, reload_next;
  logic                tc_reg, tc_next;
  logic                advance;
  logic                tick;

  assign advance = en && (state_reg == RUN) && !load;

`ifdef DOWN_COUNTER_PRESCALE_EN
  down_counter_prescaler #(
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .clr_i    (clr_i),
    .clear    (load),
    .advance  (advance),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = advance;
`endif

  always_ff @(posedge clk or negedge clr_i) begin
    if (!clr_i) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    if (load) begin
      reload_next = load_val;
      count_next  = load_val;
      state_next  = (load_val != '0) ? RUN : IDLE;
    end else if (tick) begin
      if (count_reg > DC_WIDTH'(1)) begin
        count_next = count_reg - DC_WIDTH'(1);
      end else begin
        // Terminal tick: auto is only consulted here.
        tc_next = 1'b1;
        if (auto) begin
          count_next = reload_reg;
        end else begin
          count_next = '0;
          state_next = DONE;
        end
      end
    end
  end

  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  assign count   = count_reg;
  assign count_n = ~count_reg;
  assign tc      = tc_reg;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (DC_WIDTH=3); the prescaler
// expectations follow DOWN_COUNTER_PRESCALE_EN.
module tb_down_counter;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         clr_i;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto;
  logic [W-1:0] count;
  logic [W-1:0] count_n;
  logic         tc;
  logic         done;
  logic         busy;
`ifdef DOWN_COUNTER_PRESCALE_EN
  logic [3:0]   prescale;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  down_counter #(
    .DC_WIDTH (W)
  ) dut (
    .clk      (clk),
    .clr_i    (clr_i),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .auto     (auto),
`ifdef DOWN_COUNTER_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .count_n  (count_n),
    .tc       (tc),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d busy=%0b done=%0b tc=%0b, expected 0 0 0 0",
               count, busy, done, tc);
    end
    n_checks++;
    if (count_n !== 3'd7) begin
      n_fail++;
      $display("FAIL reset_count_n: got %0d expected 7", count_n);
    end
    // load/en present while still in reset must be ignored
    load = 1'b1; load_val = 3'd5; en = 1'b1;
    step();
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ignores_load: got count=%0d busy=%0b expected 0 0", count, busy);
    end
    clr_i = 1'b1; load = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_cnt [5] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    auto = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd5;
    step();
    load = 1'b0;
    n_checks++;
    if (count !== 3'd5 || busy !== 1'b1 || tc !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_c1: got count=%0d busy=%0b tc=%0b done=%0b, expected 5 1 0 0",
               count, busy, tc, done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (count !== exp_cnt[i] || tc !== (i == 4) || done !== (i == 4) || busy !== (i != 4)) begin
        n_fail++;
        $display("FAIL oneshot_c%0d: got count=%0d tc=%0b done=%0b busy=%0b, expected %0d %0b %0b %0b",
                 i + 2, count, tc, done, busy, exp_cnt[i], (i == 4), (i == 4), (i != 4));
      end
    end
    step();
    n_checks++;
    if (count !== 3'd0 || tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_hold_done: got count=%0d tc=%0b done=%0b busy=%0b, expected 0 0 1 0",
               count, tc, done, busy);
    end
    $display("test_one_shot: load 5 checked through DONE");
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_cnt [7] = '{3'd3, 3'd2, 3'd1, 3'd3, 3'd2, 3'd1, 3'd3};
    logic         exp_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    auto = 1'b1; en = 1'b1; load = 1'b1; load_val = 3'd3;
    step();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i != 0) step();
      n_checks++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i] || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL auto_c%0d: got count=%0d tc=%0b done=%0b busy=%0b, expected %0d %0b 0 1",
                 i + 1, count, tc, done, busy, exp_cnt[i], exp_tc[i]);
      end
    end
    $display("test_auto_reload: load 3 checked over two periods");
  endtask

  task automatic test_zero_load_pause();
    load = 1'b1; load_val = 3'd0; en = 1'b1; auto = 1'b0;
    step();
    load = 1'b0;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0 || count_n !== 3'd7) begin
      n_fail++;
      $display("FAIL zero_load: got count=%0d busy=%0b done=%0b tc=%0b count_n=%0d, expected 0 0 0 0 7",
               count, busy, done, tc, count_n);
    end
    step();
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_en: got count=%0d busy=%0b tc=%0b expected 0 0 0", count, busy, tc);
    end
    load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if (count !== 3'd2 || count_n !== 3'd5) begin
      n_fail++;
      $display("FAIL pause_reach2: got count=%0d count_n=%0d expected 2 5", count, count_n);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if (count !== 3'd2 || busy !== 1'b1 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold%0d: got count=%0d busy=%0b tc=%0b expected 2 1 0", i, count, busy, tc);
      end
    end
    en = 1'b1;
    step();
    n_checks++;
    if (count !== 3'd1) begin
      n_fail++;
      $display("FAIL pause_resume: got %0d expected 1", count);
    end
    $display("test_zero_load_pause: zero load and 5-cycle pause checked");
  endtask

  task automatic test_reset_reload_mid_run();
    auto = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd6;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL midrun_reach4: got %0d expected 4", count);
    end
    clr_i = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got count=%0d busy=%0b tc=%0b done=%0b expected 0 0 0 0",
               count, busy, tc, done);
    end
    #3;
    clr_i = 1'b1; load = 1'b1; load_val = 3'd5;
    step();
    load = 1'b0;
    step();
    step();
    n_checks++;
    if (count !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_run: got count=%0d busy=%0b expected 3 1", count, busy);
    end
    load = 1'b1; load_val = 3'd6;
    step();
    load = 1'b0;
    n_checks++;
    if (count !== 3'd6 || tc !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_mid_run: got count=%0d tc=%0b busy=%0b expected 6 0 1", count, tc, busy);
    end
    $display("test_reset_reload_mid_run: async clear and reload checked");
  endtask

  task automatic test_prescaler();
`ifdef DOWN_COUNTER_PRESCALE_EN
    localparam int N = 5;
    logic [W-1:0] exp_cnt [N] = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    logic         exp_tc  [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prescale = 4'd1;
`else
    localparam int N = 3;
    logic [W-1:0] exp_cnt [N] = '{3'd2, 3'd1, 3'd0};
    logic         exp_tc  [N] = '{1'b0, 1'b0, 1'b1};
`endif
    int tc_seen = 0;
    auto = 1'b0; en = 1'b1; load = 1'b1; load_val = 3'd2;
    step();
    load = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i != 0) step();
      if (tc === 1'b1) tc_seen++;
      n_checks++;
      if (count !== exp_cnt[i] || tc !== exp_tc[i]) begin
        n_fail++;
        $display("FAIL prescale_c%0d: got count=%0d tc=%0b expected %0d %0b",
                 i + 1, count, tc, exp_cnt[i], exp_tc[i]);
      end
    end
    step();
    if (tc === 1'b1) tc_seen++;
    n_checks++;
    if (tc_seen != 1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL prescale_tc_once: got tc_count=%0d done=%0b expected 1 1", tc_seen, done);
    end
    $display("test_prescaler: load 2 sequence checked");
  endtask

  initial begin
    clr_i = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; auto = 1'b0;
`ifdef DOWN_COUNTER_PRESCALE_EN
    prescale = '0;
`endif
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_zero_load_pause();
    test_reset_reload_mid_run();
    test_prescaler();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
